// File: rtl/cat_pkg.sv
// -----------------------------------------------------------------------------
// cat_pkg
// Shared constants and types for the Cat Trap game-state engine:
//   - board size, cell codes and game_state encodings
//   - internal FSM state type
//   - cat home position
//   - edge_dist(): distance of a cell from the nearest board edge
// -----------------------------------------------------------------------------
package cat_pkg;

    localparam int GRID_N = 8;

    localparam logic [1:0] CELL_FREE  = 2'b00;
    localparam logic [1:0] CELL_BLOCK = 2'b01;
    localparam logic [1:0] CELL_CAT   = 2'b10;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_LOSE = 2'b10;
    localparam logic [1:0] GS_WIN  = 2'b11;

    localparam logic [2:0] CAT_HOME_ROW = 3'd3;
    localparam logic [2:0] CAT_HOME_COL = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY_WAIT,
        ST_SEARCH,
        ST_COMMIT,
        ST_WIN,
        ST_LOSE
    } fsm_state_e;

    // min(r, c, 7-r, 7-c)
    function automatic logic [2:0] edge_dist(input logic [2:0] r, input logic [2:0] c);
        logic [2:0] d;
        d = r;
        if (c < d)           d = c;
        if ((3'd7 - r) < d)  d = 3'd7 - r;
        if ((3'd7 - c) < d)  d = 3'd7 - c;
        return d;
    endfunction

endpackage

// File: rtl/cat_nbr_search.sv
// -----------------------------------------------------------------------------
// cat_nbr_search
// Four-cycle neighbour scan around the cat. One neighbour is evaluated per
// enabled cycle in the order up, right, down, left. Blocked neighbours are
// skipped; the free neighbour closest to the edge is kept, earlier k wins ties.
// Ports:
//   clk, reset            clock, async active-high reset
//   clr                   restart the scan (k = 0, no candidate)
//   en                    evaluate neighbour k this cycle
//   cat_row, cat_col      cat position being scanned around
//   grid                  blocked-cell bitmap, index {row, col}
//   last                  this cycle evaluates the final neighbour
//   found                 at least one free neighbour seen
//   best_row, best_col    selected neighbour
//   best_dist             edge distance of the selected neighbour
// -----------------------------------------------------------------------------
module cat_nbr_search (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [2:0]  cat_row,
    input  logic [2:0]  cat_col,
    input  logic [63:0] grid,
    output logic        last,
    output logic        found,
    output logic [2:0]  best_row,
    output logic [2:0]  best_col,
    output logic [2:0]  best_dist
);
    import cat_pkg::*;

    logic [1:0] k_q, k_d;
    logic       found_q, found_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [2:0] dist_q, dist_d;

    logic [2:0] nbr_row, nbr_col, nbr_dist;
    logic       nbr_blk;

    always_comb begin
        nbr_row = cat_row;
        nbr_col = cat_col;
        case (k_q)
            2'd0: nbr_row = cat_row - 3'd1;
            2'd1: nbr_col = cat_col + 3'd1;
            2'd2: nbr_row = cat_row + 3'd1;
            default: nbr_col = cat_col - 3'd1;
        endcase
        nbr_dist = edge_dist(nbr_row, nbr_col);
        nbr_blk  = grid[{nbr_row, nbr_col}];
    end

    always_comb begin
        k_d     = k_q;
        found_d = found_q;
        row_d   = row_q;
        col_d   = col_q;
        dist_d  = dist_q;
        if (clr) begin
            k_d     = 2'd0;
            found_d = 1'b0;
            row_d   = 3'd0;
            col_d   = 3'd0;
            dist_d  = 3'd0;
        end else if (en) begin
            k_d = k_q + 2'd1;
            // strict less-than keeps the earlier neighbour on a tie
            if (!nbr_blk && (!found_q || (nbr_dist < dist_q))) begin
                found_d = 1'b1;
                row_d   = nbr_row;
                col_d   = nbr_col;
                dist_d  = nbr_dist;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q     <= 2'd0;
            found_q <= 1'b0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            dist_q  <= 3'd0;
        end else begin
            k_q     <= k_d;
            found_q <= found_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dist_q  <= dist_d;
        end
    end

    assign last      = en && (k_q == 2'd3);
    assign found     = found_q;
    assign best_row  = row_q;
    assign best_col  = col_q;
    assign best_dist = dist_q;

endmodule

// File: rtl/cat_board_ctrl.sv
// -----------------------------------------------------------------------------
// cat_board_ctrl
// Game-state engine for the Cat Trap board: owns the 8x8 blocked-cell grid and
// the cat position, accepts player selections, moves the cat and declares
// WIN / LOSE. Renderer reads one cell per cycle through a registered port.
//
// Optional build macro: CAT_RAND_START_EN
//   defined   -> a free-running 2-bit counter picks one of the four centre
//                cells as the cat start position at each start
//   undefined -> cat always starts at (3,3)
//
// Ports:
//   clk, reset               clock, async active-high reset
//   start                    new game (IDLE, WIN, LOSE only)
//   sel_valid/row/col        player selection; sel_ready accepts it
//   sel_err                  one-cycle pulse on a rejected selection
//   rd_row, rd_col, rd_cell  renderer read port, 1-cycle latency
//   cat_row, cat_col         current cat position
//   game_state               00 IDLE, 01 PLAY, 10 LOSE, 11 WIN
//   move_done                one-cycle pulse after each cat-move commit
//   move_count               accepted selections since start, saturating
//
// FSM states:
//   state      | meaning
//   IDLE       | after reset, waiting for start
//   PLAY_WAIT  | waiting for a player selection
//   SEARCH     | scanning the four neighbours (4 cycles)
//   COMMIT     | moving the cat / deciding WIN or LOSE
//   WIN        | cat trapped, waiting for start
//   LOSE       | cat reached the edge, waiting for start
// -----------------------------------------------------------------------------
module cat_board_ctrl #(
    parameter int GRID_N     = 8,
    parameter int MOVE_CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sel_valid,
    input  logic [2:0]            sel_row,
    input  logic [2:0]            sel_col,
    output logic                  sel_ready,
    output logic                  sel_err,
    input  logic [2:0]            rd_row,
    input  logic [2:0]            rd_col,
    output logic [1:0]            rd_cell,
    output logic [2:0]            cat_row,
    output logic [2:0]            cat_col,
    output logic [1:0]            game_state,
    output logic                  move_done,
    output logic [MOVE_CNT_W-1:0] move_count
);
    import cat_pkg::*;

    localparam int CELLS = GRID_N * GRID_N;

    fsm_state_e            state_q, state_d;
    logic [CELLS-1:0]      grid_q, grid_d;
    logic [2:0]            cat_row_q, cat_row_d;
    logic [2:0]            cat_col_q, cat_col_d;
    logic [MOVE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  sel_err_q, sel_err_d;
    logic                  move_done_q, move_done_d;
    logic [1:0]            rd_cell_q, rd_cell_d;

    logic [2:0] home_row, home_col;

`ifdef CAT_RAND_START_EN
    logic [1:0] rnd_q, rnd_d;

    assign rnd_d    = rnd_q + 2'd1;
    assign home_row = CAT_HOME_ROW + {2'b00, rnd_q[1]};
    assign home_col = CAT_HOME_COL + {2'b00, rnd_q[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rnd_q <= 2'd0;
        else       rnd_q <= rnd_d;
    end
`else
    assign home_row = CAT_HOME_ROW;
    assign home_col = CAT_HOME_COL;
`endif

    logic       sel_bad;
    logic       scan_clr, scan_en, scan_last, scan_found;
    logic [2:0] best_row, best_col, best_dist;

    assign sel_bad  = grid_q[{sel_row, sel_col}] ||
                      ((sel_row == cat_row_q) && (sel_col == cat_col_q));
    assign scan_clr = (state_q == ST_PLAY_WAIT) && sel_valid && !sel_bad;
    assign scan_en  = (state_q == ST_SEARCH);

    // The blocked bit is written on the accept edge, so the scan already
    // sees the newly blocked cell.
    cat_nbr_search u_search (
        .clk       (clk),
        .reset     (reset),
        .clr       (scan_clr),
        .en        (scan_en),
        .cat_row   (cat_row_q),
        .cat_col   (cat_col_q),
        .grid      (grid_q),
        .last      (scan_last),
        .found     (scan_found),
        .best_row  (best_row),
        .best_col  (best_col),
        .best_dist (best_dist)
    );

    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        cat_row_d   = cat_row_q;
        cat_col_d   = cat_col_q;
        cnt_d       = cnt_q;
        sel_err_d   = 1'b0;
        move_done_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    grid_d    = '0;
                    cat_row_d = home_row;
                    cat_col_d = home_col;
                    cnt_d     = '0;
                    state_d   = ST_PLAY_WAIT;
                end
            end
            ST_PLAY_WAIT: begin
                if (sel_valid) begin
                    if (sel_bad) begin
                        sel_err_d = 1'b1;
                    end else begin
                        grid_d[{sel_row, sel_col}] = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        state_d = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (scan_last) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                move_done_d = 1'b1;
                if (!scan_found) begin
                    state_d = ST_WIN;
                end else begin
                    cat_row_d = best_row;
                    cat_col_d = best_col;
                    state_d   = (best_dist == 3'd0) ? ST_LOSE : ST_PLAY_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Uses registered board state, so a read on the commit edge sees the
    // pre-commit board. Cat takes priority over blocked.
    always_comb begin
        if ((rd_row == cat_row_q) && (rd_col == cat_col_q))
            rd_cell_d = CELL_CAT;
        else if (grid_q[{rd_row, rd_col}])
            rd_cell_d = CELL_BLOCK;
        else
            rd_cell_d = CELL_FREE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grid_q      <= '0;
            cat_row_q   <= CAT_HOME_ROW;
            cat_col_q   <= CAT_HOME_COL;
            cnt_q       <= '0;
            sel_err_q   <= 1'b0;
            move_done_q <= 1'b0;
            rd_cell_q   <= CELL_FREE;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            cat_row_q   <= cat_row_d;
            cat_col_q   <= cat_col_d;
            cnt_q       <= cnt_d;
            sel_err_q   <= sel_err_d;
            move_done_q <= move_done_d;
            rd_cell_q   <= rd_cell_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_IDLE:  game_state = GS_IDLE;
            ST_WIN:   game_state = GS_WIN;
            ST_LOSE:  game_state = GS_LOSE;
            default:  game_state = GS_PLAY;
        endcase
    end

    assign sel_ready  = (state_q == ST_PLAY_WAIT);
    assign sel_err    = sel_err_q;
    assign move_done  = move_done_q;
    assign move_count = cnt_q;
    assign cat_row    = cat_row_q;
    assign cat_col    = cat_col_q;
    assign rd_cell    = rd_cell_q;

endmodule
